// File: rtl/usb_pkg.sv
// Types and constants shared by the USB transmit path (CRC serialiser,
// bit stuffer, NRZI encoder).
package usb_pkg;
  typedef enum logic [1:0] {STF_IDLE, STF_PASS, STF_STUFF} stuff_state_t;

  localparam int USB_STUFF_RUN   = 6;
  localparam int USB_STUFF_CNT_W = 5;

  localparam int USB_PID_W   = 8;
  localparam int USB_ADDR_W  = 7;
  localparam int USB_ENDP_W  = 4;
  localparam int USB_CRC5_W  = 5;
  localparam int USB_CRC16_W = 16;
endpackage

// File: rtl/bit_stuffer_if.sv
// Serial stream handshake between the CRC serialiser, the bit stuffer and
// the NRZI encoder, plus the per-packet stuffed-bit count.
interface bit_stuffer_if
  import usb_pkg::*;
#(
  parameter int CNT_W = USB_STUFF_CNT_W
);
  logic             in_bit;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             out_bit;
  logic             out_valid;
  logic             out_last;
  logic [CNT_W-1:0] stuff_cnt;

  modport master (
    output in_bit, in_valid, in_last,
    input  in_ready, out_bit, out_valid, out_last, stuff_cnt
  );

  modport slave (
    input  in_bit, in_valid, in_last,
    output in_ready, out_bit, out_valid, out_last, stuff_cnt
  );
endinterface

// File: rtl/ones_run_counter.sv
// Counts consecutive accepted 1s and flags the beat that completes a run of
// RUN_LEN; the counter wraps to zero on that beat.
module ones_run_counter
  import usb_pkg::*;
#(
  parameter int RUN_LEN = USB_STUFF_RUN,
  localparam int W      = $clog2(RUN_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic zero,
  output logic run_done
);
  logic [W-1:0] ones_cnt_q;
  logic [W-1:0] ones_cnt_d;

  assign run_done = inc && (ones_cnt_q == W'(RUN_LEN - 1));

  // clr (end of packet) wins over inc so a run finishing on in_last still
  // reports run_done but leaves the counter empty for the next packet.
  always_comb begin
    ones_cnt_d = ones_cnt_q;
    if (clr) begin
      ones_cnt_d = '0;
    end else if (inc) begin
      ones_cnt_d = run_done ? '0 : ones_cnt_q + W'(1);
    end else if (zero) begin
      ones_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt_q <= '0;
    end else begin
      ones_cnt_q <= ones_cnt_d;
    end
  end
endmodule

// File: rtl/bit_stuffer.sv
// USB bit stuffer: inserts a 0 after every RUN_LEN consecutive 1s, stalling
// upstream for the inserted cycle; registered outputs feed the NRZI encoder.
module bit_stuffer
  import usb_pkg::*;
#(
  parameter int RUN_LEN = USB_STUFF_RUN,
  parameter int CNT_W   = USB_STUFF_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  bit_stuffer_if.slave  bus
);
  stuff_state_t     state_q, state_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             last_pend_q, last_pend_d;
  logic [CNT_W-1:0] stuff_cnt_q, stuff_cnt_d;

  logic in_ready;
  logic beat;
  logic run_done;

  assign in_ready = (state_q != STF_STUFF);
  assign beat     = bus.in_valid && in_ready;

  ones_run_counter #(.RUN_LEN(RUN_LEN)) u_ones (
    .clk      (clk),
    .rst      (rst),
    .clr      (beat && bus.in_last),
    .inc      (beat && bus.in_bit),
    .zero     (beat && !bus.in_bit),
    .run_done (run_done)
  );

  always_comb begin
    state_d     = state_q;
    out_bit_d   = 1'b0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    last_pend_d = last_pend_q;
    stuff_cnt_d = stuff_cnt_q;
    unique case (state_q)
      STF_IDLE, STF_PASS: begin
        if (beat) begin
          out_bit_d   = bus.in_bit;
          out_valid_d = 1'b1;
          if (state_q == STF_IDLE) begin
            stuff_cnt_d = '0;
          end
          // A run ending on in_last hands the last flag to the stuffed 0.
          if (run_done) begin
            state_d     = STF_STUFF;
            last_pend_d = bus.in_last;
          end else begin
            out_last_d = bus.in_last;
            state_d    = bus.in_last ? STF_IDLE : STF_PASS;
          end
        end
      end
      STF_STUFF: begin
        out_valid_d = 1'b1;
        out_last_d  = last_pend_q;
        stuff_cnt_d = (stuff_cnt_q == '1) ? stuff_cnt_q : stuff_cnt_q + CNT_W'(1);
        state_d     = last_pend_q ? STF_IDLE : STF_PASS;
        last_pend_d = 1'b0;
      end
      default: state_d = STF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STF_IDLE;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      last_pend_q <= 1'b0;
      stuff_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      last_pend_q <= last_pend_d;
      stuff_cnt_q <= stuff_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.stuff_cnt = stuff_cnt_q;
endmodule

// File: tb/tb_bit_stuffer.sv
// Directed bench for bit_stuffer: a reference stuffing model pushes expected
// output bits into a scoreboard queue, popped as the DUT emits them.
module tb_bit_stuffer;
  import usb_pkg::*;

  localparam int RUN = 6;
  localparam int CW  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit_stuffer_if #(.CNT_W(CW)) bus ();

  bit_stuffer #(.RUN_LEN(RUN), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         fail_cnt = 0;
  int         ready_low = 0;
  int         out_n = 0;
  logic [1:0] exp_q[$];

  int m_ones = 0;
  int m_cnt = 0;
  bit m_stuff = 1'b0;
  bit m_last_pend = 1'b0;
  bit m_in_pkt = 1'b0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with inputs set; advances one clock.
  task automatic tick();
    bit         pushed;
    logic [1:0] e;
    pushed = 1'b0;
    check("in_ready", 32'(bus.in_ready), 32'(!m_stuff));
    if (!bus.in_ready) ready_low++;
    if (rst) begin
      m_ones = 0; m_cnt = 0; m_stuff = 0; m_last_pend = 0; m_in_pkt = 0;
      exp_q.delete();
    end else if (m_stuff) begin
      exp_q.push_back({1'b0, m_last_pend});
      m_stuff = 1'b0;
      if (m_cnt != (1 << CW) - 1) m_cnt++;
      m_in_pkt = !m_last_pend;
      pushed = 1'b1;
    end else if (bus.in_valid) begin
      if (!m_in_pkt) m_cnt = 0;
      pushed = 1'b1;
      if (bus.in_bit) m_ones++;
      else m_ones = 0;
      if (m_ones == RUN) begin
        m_ones = 0;
        m_stuff = 1'b1;
        m_last_pend = bus.in_last;
        m_in_pkt = 1'b1;
        exp_q.push_back({bus.in_bit, 1'b0});
      end else begin
        exp_q.push_back({bus.in_bit, bus.in_last});
        if (bus.in_last) begin
          m_ones = 0;
          m_in_pkt = 1'b0;
        end else begin
          m_in_pkt = 1'b1;
        end
      end
    end
    @(negedge clk);
    check("out_valid", 32'(bus.out_valid), 32'(pushed));
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("out_bit", 32'(bus.out_bit), 32'(e[1]));
        check("out_last", 32'(bus.out_last), 32'(e[0]));
        out_n++;
      end
    end
    check("stuff_cnt", 32'(bus.stuff_cnt), 32'(m_cnt));
  endtask

  task automatic send(bit b, bit l);
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_last  = l;
    if (m_stuff) tick();
    tick();
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_ones(int n, bit last_on_final);
    for (int i = 0; i < n; i++) send(1'b1, last_on_final && (i == n - 1));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_test();
    out_n = 0;
    ready_low = 0;
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_bit", 32'(bus.out_bit), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_stuff_cnt", 32'(bus.stuff_cnt), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    // 0101_0101 sent LSB first: nothing to stuff.
    start_test();
    pat = 8'b0101_0101;
    for (int i = 0; i < 8; i++) send(pat[i], i == 7);
    idle(1);
    check("t1_out_n", 32'(out_n), 32'd8);
    check("t1_ready_low", 32'(ready_low), 32'd0);
    check("t1_stuff_cnt", 32'(bus.stuff_cnt), 32'd0);

    start_test();
    send_ones(12, 1'b0);
    send(1'b0, 1'b1);
    idle(2);
    check("t2_out_n", 32'(out_n), 32'd15);
    check("t2_ready_low", 32'(ready_low), 32'd2);
    check("t2_stuff_cnt", 32'(bus.stuff_cnt), 32'd2);

    start_test();
    send_ones(6, 1'b1);
    idle(1);
    check("t3_out_n", 32'(out_n), 32'd7);
    check("t3_state", 32'(dut.state_q), 32'(STF_IDLE));
    check("t3_stuff_cnt", 32'(bus.stuff_cnt), 32'd1);
    idle(1);

    start_test();
    send_ones(5, 1'b0);
    idle(3);
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    idle(1);
    check("t4_out_n", 32'(out_n), 32'd8);
    check("t4_stuff_cnt", 32'(bus.stuff_cnt), 32'd1);

    // Reset lands on the STUFF cycle: the stuffed bit must vanish.
    start_test();
    send_ones(6, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_out_bit", 32'(bus.out_bit), 32'd0);
    check("t5_out_last", 32'(bus.out_last), 32'd0);
    check("t5_in_ready", 32'(bus.in_ready), 32'd1);
    check("t5_out_n", 32'(out_n), 32'd6);
    start_test();
    send_ones(5, 1'b1);
    idle(1);
    check("t5b_out_n", 32'(out_n), 32'd5);
    check("t5b_ready_low", 32'(ready_low), 32'd0);
    check("t5b_stuff_cnt", 32'(bus.stuff_cnt), 32'd0);

    start_test();
    send_ones(7, 1'b1);
    idle(2);
    check("t6_out_n", 32'(out_n), 32'd8);
    check("t6_cnt_held", 32'(bus.stuff_cnt), 32'd1);
    send(1'b1, 1'b0);
    check("t6_cnt_cleared", 32'(bus.stuff_cnt), 32'd0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    idle(2);
    check("t6_out_n2", 32'(out_n), 32'd11);
    check("sb_left", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
